// File: rtl/md5_msg_padder_if.sv
// Stream interface between the message feeder, the MD5 padder and the round
// engine. The byte stream enters on the in_* signals and padded 512-bit
// blocks leave on the out_* signals. The padder uses the slave modport; the
// feeder/consumer side uses the master modport.
interface md5_msg_padder_if;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [7:0]   in_data_i;
    logic         in_last_i;
    logic         in_empty_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [511:0] out_block_o;
    logic         out_first_o;
    logic         out_last_o;

    modport slave (
        input  in_valid_i, in_data_i, in_last_i, in_empty_i, out_ready_i,
        output in_ready_o, out_valid_o, out_block_o, out_first_o, out_last_o
    );

    modport master (
        output in_valid_i, in_data_i, in_last_i, in_empty_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_block_o, out_first_o, out_last_o
    );
endinterface

// File: rtl/md5_msg_padder.sv
// MD5 message padder: collects message bytes into a 64-byte buffer and emits
// 512-bit blocks with MD5 padding (0x80, zero fill, 64-bit little-endian bit
// length). out_first marks the block where the core loads its IV, out_last
// the block after which the digest is final.
// Optional statistics counters are built when MD5_PADDER_STATS_EN is defined;
// otherwise msg_count_o / blk_count_o are tied to zero.
module md5_msg_padder #(
    parameter int LEN_W = 64
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    md5_msg_padder_if.slave     bus,
    output logic [31:0]         msg_count_o,
    output logic [31:0]         blk_count_o
);

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_PAD  = 2'd1,
        ST_LEN  = 2'd2,
        ST_EMIT = 2'd3
    } state_t;

    state_t             state_r;
    logic [511:0]       buf_r;
    logic [6:0]         byte_idx_r;
    logic [LEN_W-1:0]   bit_cnt_r;
    logic               first_r;
    logic               emit_last_r;   // block being emitted ends the message
    logic               pend_pad_r;    // full data block taken with the last beat: pad next
    logic               pend_len_r;    // 0x80 landed in bytes 56..63: length goes in next block
    logic               in_ready_r;
    logic               out_valid_r;
    logic               out_first_r;
    logic               out_last_r;

    logic               in_hs_s;
    logic               out_hs_s;
    logic [6:0]         idx_inc_s;
    logic               byte_s;

    assign in_hs_s   = bus.in_valid_i & in_ready_r;
    assign out_hs_s  = out_valid_r & bus.out_ready_i;
    assign idx_inc_s = byte_idx_r + 7'd1;
    assign byte_s    = ~bus.in_empty_i;

    assign bus.in_ready_o  = in_ready_r;
    assign bus.out_valid_o = out_valid_r;
    assign bus.out_block_o = buf_r;
    assign bus.out_first_o = out_first_r;
    assign bus.out_last_o  = out_last_r;

    // Main padding FSM: buffer fill, 0x80 marker, length field and block emit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= ST_FILL;
            buf_r       <= 512'd0;
            byte_idx_r  <= 7'd0;
            bit_cnt_r   <= '0;
            first_r     <= 1'b1;
            emit_last_r <= 1'b0;
            pend_pad_r  <= 1'b0;
            pend_len_r  <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_first_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else if (clear_i) begin
            // Abort wins over everything, including a beat presented this cycle.
            state_r     <= ST_FILL;
            buf_r       <= 512'd0;
            byte_idx_r  <= 7'd0;
            bit_cnt_r   <= '0;
            first_r     <= 1'b1;
            emit_last_r <= 1'b0;
            pend_pad_r  <= 1'b0;
            pend_len_r  <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_first_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_FILL: begin
                    in_ready_r <= 1'b1;
                    if (in_hs_s) begin
                        if (byte_s) begin
                            buf_r[{byte_idx_r[5:0], 3'b000} +: 8] <= bus.in_data_i;
                            byte_idx_r <= idx_inc_s;
                            bit_cnt_r  <= bit_cnt_r + LEN_W'(4'd8);
                        end
                        if (bus.in_last_i) begin
                            in_ready_r <= 1'b0;
                            if (byte_s && (idx_inc_s == 7'd64)) begin
                                state_r     <= ST_EMIT;
                                emit_last_r <= 1'b0;
                                pend_pad_r  <= 1'b1;
                            end else begin
                                state_r <= ST_PAD;
                            end
                        end else if (byte_s && (idx_inc_s == 7'd64)) begin
                            in_ready_r  <= 1'b0;
                            state_r     <= ST_EMIT;
                            emit_last_r <= 1'b0;
                        end
                    end
                end
                ST_PAD: begin
                    in_ready_r <= 1'b0;
                    buf_r[{byte_idx_r[5:0], 3'b000} +: 8] <= 8'h80;
                    if (byte_idx_r <= 7'd55) begin
                        state_r <= ST_LEN;
                    end else begin
                        state_r     <= ST_EMIT;
                        emit_last_r <= 1'b0;
                        pend_len_r  <= 1'b1;
                    end
                end
                ST_LEN: begin
                    in_ready_r     <= 1'b0;
                    buf_r[511:448] <= 64'(bit_cnt_r);
                    state_r        <= ST_EMIT;
                    emit_last_r    <= 1'b1;
                end
                ST_EMIT: begin
                    in_ready_r <= 1'b0;
                    if (!out_valid_r) begin
                        // Buffer settled last cycle; present it and hold until taken.
                        out_valid_r <= 1'b1;
                        out_first_r <= first_r;
                        out_last_r  <= emit_last_r;
                    end else if (out_hs_s) begin
                        out_valid_r <= 1'b0;
                        out_first_r <= 1'b0;
                        out_last_r  <= 1'b0;
                        buf_r       <= 512'd0;
                        byte_idx_r  <= 7'd0;
                        first_r     <= 1'b0;
                        if (emit_last_r) begin
                            state_r    <= ST_FILL;
                            in_ready_r <= 1'b1;
                            bit_cnt_r  <= '0;
                            first_r    <= 1'b1;
                        end else if (pend_len_r) begin
                            state_r    <= ST_LEN;
                            pend_len_r <= 1'b0;
                        end else if (pend_pad_r) begin
                            state_r    <= ST_PAD;
                            pend_pad_r <= 1'b0;
                        end else begin
                            state_r    <= ST_FILL;
                            in_ready_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r    <= ST_FILL;
                    in_ready_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef MD5_PADDER_STATS_EN
    logic [31:0] msg_cnt_r;
    logic [31:0] blk_cnt_r;

    // Completed-message and emitted-block counters; survive clear_i on purpose.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            msg_cnt_r <= 32'd0;
            blk_cnt_r <= 32'd0;
        end else if (out_hs_s && !clear_i) begin
            blk_cnt_r <= blk_cnt_r + 32'd1;
            if (out_last_r) begin
                msg_cnt_r <= msg_cnt_r + 32'd1;
            end
        end
    end

    assign msg_count_o = msg_cnt_r;
    assign blk_count_o = blk_cnt_r;
`else
    assign msg_count_o = 32'd0;
    assign blk_count_o = 32'd0;
`endif

endmodule

// File: doc/md5_msg_padder.md
Name: md5_msg_padder

Overview:
- Upstream feeder for the MD5 core. Accepts a byte stream per message and emits 512-bit blocks with MD5 padding applied.
- Padding: 0x80 after the last byte, zero fill, then the 64-bit little-endian bit length.
- Block flags tell the core when to reinitialise its chaining state and when the digest is final.
- Sits between the AXI4-lite message register file and the MD5 round engine.

Parameters:
- LEN_W, 64, width of the bit-length counter (≤64). Length bits above LEN_W are emitted as 0. The count wraps mod 2^LEN_W.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous soft abort. Drops the current message and the buffer.
- in_valid_i  in  1  input beat valid
- in_ready_o  out  1  input beat accepted when valid&ready
- in_data_i  in  8  message byte
- in_last_i  in  1  final beat of the message
- in_empty_i  in  1  beat carries no byte. Only legal with in_last_i, e.g. for an empty message.
- out_valid_o  out  1  block valid
- out_ready_i  in  1  block consumed when valid&ready
- out_block_o  out  512  block; byte k is at bits [8k+7:8k]
- out_first_o  out  1  first block of the message (core loads IV)
- out_last_o  out  1  final block of the message (digest ready after it)
- msg_count_o  out  32  completed messages (see Optional Feature)
- blk_count_o  out  32  emitted blocks (see Optional Feature)

Behaviour:
- Reset (async, rst_ni=0) clears all state:
  - Outputs: in_ready_o=0, out_valid_o=0, out_first_o=0, out_last_o=0, out_block_o=0, counts=0.
  - Internal: buffer=0, byte_idx=0, bit_cnt=0, first_flag=1, state=FILL.
  - In the cycle after release, in_ready_o=1.
- FILL state:
  - in_ready_o=1.
  - Each accepted non-empty beat writes buf[byte_idx], byte_idx+=1, bit_cnt+=8.
  - byte_idx reaches 64 and the beat is not last → EMIT with last=0.
  - Accepted beat has in_last_i=1 → PAD. This includes the case where byte_idx reaches 64 on that beat: the full block is emitted in EMIT as non-last, then the next block is padded.
- PAD state (1 cycle, in_ready_o=0):
  - Write 0x80 at buf[byte_idx].
  - byte_idx≤55 → LEN.
  - byte_idx 56..63 → EMIT with last=0, then LEN.
- LEN state (1 cycle): write bit_cnt little-endian to bytes 56..63 → EMIT with last=1.
- EMIT state:
  - out_valid_o=1. out_block_o, out_first_o=first_flag and out_last_o are held stable until out_ready_i. in_ready_o=0.
  - On handshake: buffer cleared to 0, byte_idx=0, first_flag=0.
  - Return to FILL if the message is still open. Return to LEN if padding overflowed.
  - After last=1: return to FILL with bit_cnt=0 and first_flag=1.
- Latency:
  - 64th non-last byte accepted at edge k → out_valid_o high after edge k+1.
  - Last beat with byte_idx≤55 after writing → out_valid_o after edge k+3.
- Buffer is never read-modify-written during EMIT; the block is stable under backpressure.
- clear_i has priority over all other events in a cycle:
  - Returns to FILL, clears buffer, byte_idx, bit_cnt; first_flag=1, out_valid_o=0 next cycle.
  - A beat presented in the same cycle is dropped.
- in_empty_i=1 without in_last_i: beat accepted and ignored.
- Simultaneous in and out handshakes cannot occur; in_ready_o=0 in EMIT.

Optional Feature:
- Macro MD5_PADDER_STATS_EN.
- Defined:
  - msg_count_o increments on each out_last_o handshake.
  - blk_count_o increments on each block handshake.
  - Both wrap at 2^32. Both cleared by reset, not by clear_i.
- Undefined: both outputs are tied to 0 and no counter flops are built.

Test Plan:
- Empty message: one beat with in_empty=1, in_last=1 → one block: byte0=0x80, all other bytes 0, first=1, last=1.
- "abc" (0x61,0x62,0x63 with last) → one block: bytes 0..3 = 61 62 63 80, byte56=0x18, bytes 57..63=0, first=last=1, out_valid 3 cycles after last accept.
- 55-byte message (0x00..0x36) → single block: byte55=0x80, bytes 56,57=B8 01.
- 56-byte message → block A: byte56=0x80, last=0, first=1. Block B: all 0 except bytes 56,57=C0 01, first=0, last=1.
- 64-byte message → block A full data, last=0. Block B: byte0=0x80, bytes 56,57=00 02, last=1. With MD5_PADDER_STATS_EN: msg_count=1, blk_count=2.
- Backpressure and abort:
  - out_ready=0 for 10 cycles → out_block stable, in_ready=0.
  - clear_i after 20 bytes → no block emitted; next "abc" produces the same result as the "abc" test with first=1.
